// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types and constants for the fetch sequencer
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      ISSUE = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_t;

   localparam logic [3:0] RMASK_FULL = 4'hF;

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - instruction memory, instruction queue and redirect signals
interface fetch_ctrl_if;

   logic [31:0] imem_addr;
   logic [3:0]  imem_rmask;
   logic [31:0] imem_rdata;
   logic        imem_resp;
   logic        iq_full;
   logic        iq_push;
   logic [31:0] iq_instr;
   logic [63:0] iq_order;
   logic [31:0] iq_pc;
   logic        redirect;
   logic [31:0] redirect_pc;

   modport master (
      output imem_addr, imem_rmask,
      input  imem_rdata, imem_resp,
      input  iq_full,
      output iq_push, iq_instr, iq_order, iq_pc,
      input  redirect, redirect_pc
   );

   modport slave (
      input  imem_addr, imem_rmask,
      output imem_rdata, imem_resp,
      output iq_full,
      input  iq_push, iq_instr, iq_order, iq_pc,
      output redirect, redirect_pc
   );

endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - single-outstanding fetch sequencer feeding the instruction queue
// A redirect squashes whatever fetch is in flight or held; order only advances on push.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
   input  logic         clk,
   input  logic         rst,
   fetch_ctrl_if.master bus
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [63:0]  order;
   logic [31:0]  hold_word;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ISSUE;
         pc        <= RESET_PC;
         order     <= 64'd0;
         hold_word <= 32'd0;
      end else begin
         case (state)
            ISSUE: begin
               if (bus.redirect) pc <= bus.redirect_pc;
               else              state <= WAIT;
            end
            WAIT: begin
               if (bus.imem_resp) begin
                  if (bus.redirect) begin
                     pc    <= bus.redirect_pc;
                     state <= ISSUE;
                  end else if (!bus.iq_full) begin
                     pc    <= pc + 32'd4;
                     order <= order + 64'd1;
                     state <= ISSUE;
                  end else begin
                     hold_word <= bus.imem_rdata;
                     state     <= HOLD;
                  end
               end else if (bus.redirect) begin
                  pc    <= bus.redirect_pc;
                  state <= DRAIN;
               end
            end
            HOLD: begin
               if (bus.redirect) begin
                  pc    <= bus.redirect_pc;
                  state <= ISSUE;
               end else if (!bus.iq_full) begin
                  pc    <= pc + 32'd4;
                  order <= order + 64'd1;
                  state <= ISSUE;
               end
            end
            DRAIN: begin
               // the stale response must be swallowed before a new read may launch
               if (bus.redirect)  pc    <= bus.redirect_pc;
               if (bus.imem_resp) state <= ISSUE;
            end
            default: state <= ISSUE;
         endcase
      end
   end

   always_comb begin
      bus.imem_addr  = pc;
      bus.imem_rmask = 4'h0;
      bus.iq_push    = 1'b0;
      bus.iq_instr   = bus.imem_rdata;
      bus.iq_order   = order;
      bus.iq_pc      = pc;
      if (!rst) begin
         case (state)
            ISSUE: if (!bus.redirect) bus.imem_rmask = RMASK_FULL;
            WAIT:  if (bus.imem_resp && !bus.redirect && !bus.iq_full) bus.iq_push = 1'b1;
            HOLD: begin
               bus.iq_instr = hold_word;
               if (!bus.redirect && !bus.iq_full) bus.iq_push = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed and randomized bench for fetch_ctrl
module tb_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h1eceb000;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fetch_ctrl_if bus();

   fetch_ctrl #(.RESET_PC(RST_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference: next fetch target, tag counter, and the one word that may be in flight or parked
   logic [31:0] m_pc;
   logic [63:0] m_order;
   bit          m_pend, m_squash, m_held;
   logic [31:0] m_hword;

   bit          mem_busy;
   int          mem_cnt;
   int          lat_lo = 1, lat_hi = 1;
   bit          data_fixed = 1'b0;
   logic [31:0] fixed_word = 32'h0;
   int          pushes = 0, launches = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc     = RST_PC;
      m_order  = 64'd0;
      m_pend   = 1'b0;
      m_squash = 1'b0;
      m_held   = 1'b0;
      m_hword  = 32'd0;
      mem_busy = 1'b0;
      mem_cnt  = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst             = 1'b1;
      bus.imem_resp   = 1'b0;
      bus.imem_rdata  = $urandom;
      bus.redirect    = 1'b0;
      bus.redirect_pc = $urandom;
      bus.iq_full     = 1'b0;
      #1;
      chk("rst_rmask", {60'd0, bus.imem_rmask}, 64'd0);
      chk("rst_push", {63'd0, bus.iq_push}, 64'd0);
      model_reset();
   endtask

   task automatic cycle(input bit rd, input logic [31:0] rpc, input bit full);
      bit          resp, exp_launch, exp_push;
      logic [31:0] rdata, exp_instr;
      @(negedge clk);
      rst  = 1'b0;
      resp = 1'b0;
      if (mem_busy) begin
         if (mem_cnt == 1) begin
            resp     = 1'b1;
            mem_busy = 1'b0;
         end else begin
            mem_cnt--;
         end
      end
      rdata           = (resp && data_fixed) ? fixed_word : $urandom;
      bus.imem_resp   = resp;
      bus.imem_rdata  = rdata;
      bus.redirect    = rd;
      bus.redirect_pc = rd ? rpc : $urandom;
      bus.iq_full     = full;
      #1;
      exp_launch = !m_pend && !m_held && !rd;
      exp_push   = !rd && !full && (m_held || (m_pend && !m_squash && resp));
      exp_instr  = m_held ? m_hword : rdata;
      chk("rmask", {60'd0, bus.imem_rmask}, exp_launch ? 64'hF : 64'h0);
      chk("addr", {32'd0, bus.imem_addr}, {32'd0, m_pc});
      chk("push", {63'd0, bus.iq_push}, {63'd0, exp_push});
      if (exp_push) begin
         chk("instr", {32'd0, bus.iq_instr}, {32'd0, exp_instr});
         chk("order", bus.iq_order, m_order);
         chk("iq_pc", {32'd0, bus.iq_pc}, {32'd0, m_pc});
         pushes++;
      end
      if (rd) begin
         m_pc   = rpc;
         m_held = 1'b0;
         if (m_pend) begin
            if (resp) m_pend = 1'b0;
            else      m_squash = 1'b1;
         end
      end else if (exp_push) begin
         m_pc    = m_pc + 32'd4;
         m_order = m_order + 64'd1;
         m_held  = 1'b0;
         m_pend  = 1'b0;
      end else if (m_pend && resp) begin
         m_pend = 1'b0;
         if (!m_squash) begin
            m_held  = 1'b1;
            m_hword = rdata;
         end
      end
      if (exp_launch) begin
         m_pend   = 1'b1;
         m_squash = 1'b0;
         mem_busy = 1'b1;
         mem_cnt  = $urandom_range(lat_hi, lat_lo);
         launches++;
      end
   endtask

   initial begin
      int p0;
      bus.imem_resp   = 1'b0;
      bus.imem_rdata  = 32'd0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'd0;
      bus.iq_full     = 1'b0;

      // streaming with 1-cycle memory: one push every two cycles
      do_reset();
      data_fixed = 1'b1; fixed_word = 32'h00000013; lat_lo = 1; lat_hi = 1;
      p0 = pushes;
      repeat (6) cycle(1'b0, 32'd0, 1'b0);
      chk("throughput", 64'(pushes - p0), 64'd3);
      chk("order_after3", m_order, 64'd3);

      // queue full when the word returns, released three cycles later
      do_reset();
      fixed_word = 32'h00a00093;
      cycle(1'b0, 32'd0, 1'b0);
      repeat (3) cycle(1'b0, 32'd0, 1'b1);
      p0 = pushes;
      cycle(1'b0, 32'd0, 1'b0);
      chk("hold_push", 64'(pushes - p0), 64'd1);
      cycle(1'b0, 32'd0, 1'b0);

      // redirect in WAIT, stale response two cycles later
      do_reset();
      lat_lo = 3; lat_hi = 3;
      p0 = pushes;
      cycle(1'b0, 32'd0, 1'b0);
      cycle(1'b1, 32'h1eceb100, 1'b0);
      repeat (3) cycle(1'b0, 32'd0, 1'b0);
      chk("drain_nopush", 64'(pushes - p0), 64'd0);

      // redirect coincident with response
      do_reset();
      lat_lo = 1; lat_hi = 1;
      cycle(1'b0, 32'd0, 1'b0);
      cycle(1'b1, 32'h1eceb240, 1'b0);
      repeat (2) cycle(1'b0, 32'd0, 1'b0);

      // redirect while a word is held
      cycle(1'b0, 32'd0, 1'b0);
      cycle(1'b0, 32'd0, 1'b1);
      cycle(1'b1, 32'h1eceb300, 1'b1);
      repeat (3) cycle(1'b0, 32'd0, 1'b0);

      // two redirects while draining; latest one wins
      lat_lo = 3; lat_hi = 3;
      cycle(1'b0, 32'd0, 1'b0);
      cycle(1'b1, 32'h00000100, 1'b0);
      cycle(1'b1, 32'h00000200, 1'b0);
      repeat (3) cycle(1'b0, 32'd0, 1'b0);

      // reset in the middle of WAIT
      cycle(1'b0, 32'd0, 1'b0);
      do_reset();
      cycle(1'b0, 32'd0, 1'b0);
      chk("post_rst_order", m_order, 64'd0);

      // pc wrap past 2^32, unaligned redirect target used verbatim
      lat_lo = 1; lat_hi = 1;
      repeat (2) cycle(1'b0, 32'd0, 1'b0);
      cycle(1'b1, 32'hFFFFFFFC, 1'b0);
      repeat (4) cycle(1'b0, 32'd0, 1'b0);
      cycle(1'b1, 32'h00000003, 1'b0);
      repeat (3) cycle(1'b0, 32'd0, 1'b0);

      // randomized traffic
      data_fixed = 1'b0; lat_lo = 1; lat_hi = 4;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         cycle(($urandom % 8) == 0, $urandom, ($urandom % 3) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Front-end fetch sequencer between the instruction memory port and the instruction queue.
- Owns the PC and the 64-bit instruction order counter.
- Issues one instruction-memory read at a time and pushes each returned word into the queue with its order tag.
- Stalls while the queue reports full, and handles PC redirects from the back end by squashing in-flight or held fetches.

Parameters:
RESET_PC, 32'h1eceb000, PC loaded on reset; first fetch address.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
imem_addr  out  32  fetch address (always equals current PC)
imem_rmask  out  4  4'hF for exactly one cycle to launch a read, else 4'h0
imem_rdata  in  32  returned instruction word, valid when imem_resp=1
imem_resp  in  1  read response strobe, arrives >=1 cycle after launch
iq_full  in  1  instruction queue full
iq_push  out  1  push one entry into queue this cycle
iq_instr  out  32  instruction to push
iq_order  out  64  order tag to push
iq_pc  out  32  PC of pushed instruction
redirect  in  1  back-end redirect (branch/jump resolve), single-cycle pulse
redirect_pc  in  32  new PC, valid with redirect

Behaviour:
- One outstanding read maximum. State register fetch_state_t: ISSUE, WAIT, HOLD, DRAIN.
- Reset: state=ISSUE, pc=RESET_PC, order=0, hold register cleared. During the reset cycle: iq_push=0, imem_rmask=0. Reset mid-transaction abandons any outstanding read; the memory is reset on the same rst.
- All outputs are combinational from state and registers; iq_push may assert in the same cycle as imem_resp.

ISSUE:
- No redirect: rmask=F, addr=pc, go to WAIT.
- redirect=1: no launch, pc<=redirect_pc, stay in ISSUE.

WAIT:
- resp=1, redirect=0, iq_full=0: iq_push=1 with iq_instr=imem_rdata, iq_order=order, iq_pc=pc. Then pc<=pc+4, order<=order+1, go to ISSUE.
- resp=1, redirect=0, iq_full=1: latch rdata into the hold register, go to HOLD. No push.
- resp=1, redirect=1: discard the response, pc<=redirect_pc, go to ISSUE.
- resp=0, redirect=1: pc<=redirect_pc, go to DRAIN.

HOLD:
- iq_full=0 and no redirect: iq_push=1 with the held word, pc<=pc+4, order<=order+1, go to ISSUE.
- redirect=1: drop the held word, no push, pc<=redirect_pc, go to ISSUE. Redirect has priority over push.

DRAIN:
- resp=1: discard the response, go to ISSUE.
- redirect=1: pc<=redirect_pc (a later redirect overrides). Stay in DRAIN unless resp=1 in the same cycle.

Invariants and arithmetic:
- iq_push is never 1 while iq_full=1.
- iq_push is never 1 in ISSUE or DRAIN.
- order increments only on push; it is never reset by redirect. 64-bit wrap-around.
- pc+4 is mod 2^32.
- redirect_pc is used as given; no alignment check.

Throughput:
- With 1-cycle memory latency: one instruction per 2 cycles.

Decomposition:
- Shared package: fetch_state_t enum (ISSUE, WAIT, HOLD, DRAIN) and a localparam for the full-word rmask 4'hF.
- No sub-module; PC/order update and hold register are inline.

Test Plan:
- Reset, memory returns resp 1 cycle after each launch with data 32'h00000013, iq_full=0 -> launches at 0x1eceb000, 0x1eceb004, 0x1eceb008; pushes tagged order 0, 1, 2; one push every 2 cycles.
- iq_full=1 when resp arrives with 32'h00a00093 -> no push, state HOLD. Deassert iq_full after 3 cycles -> single push of 32'h00a00093 with order 0, then next launch at +4.
- redirect to 0x1eceb100 while in WAIT, resp arrives 2 cycles later -> response discarded, no push, next launch at 0x1eceb100, order unchanged.
- redirect and resp in the same cycle in WAIT -> no push, next cycle launches redirect_pc.
- Redirect while in HOLD -> held word never pushed; next launch at redirect_pc; order continues from pre-redirect value.
- Two redirects in DRAIN (0x100 then 0x200) -> fetch resumes at 0x200; assert rst mid-WAIT -> next launch at RESET_PC, order 0.
